vx_ahb_sub_mem: RTL and testbench

- AHB-Lite subordinate memory model with 32-bit word access.
- Sits directly downstream of the Vortex-to-AHB adapter. It consumes the 16-beat single-word NONSEQ transfer stream the adapter emits per 512-bit line.
- Supports programmable wait states and ERROR responses so the adapter's HREADY and error paths can be exercised in simulation.

---
 rtl/vx_ahb_pkg.sv | 30 +++
 rtl/vx_ahb_wait_gen.sv | 48 ++++
 rtl/vx_ahb_sub_mem.sv | 131 +++++++++++++
 tb/tb_vx_ahb_sub_mem.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_ahb_pkg.sv
// Shared AHB-Lite encodings, subordinate state type and helpers for vx_ahb_sub_mem.
package vx_ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic       HRESP_OKAY  = 1'b0;
   localparam logic       HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } sub_state_t;

   // The wait counter is only 4 bits wide, so any extra jitter clamps at 15.
   function automatic logic [3:0] sat_wait(input logic [3:0] base, input logic [1:0] extra);
      logic [4:0] sum;
      sum = {1'b0, base} + {3'b000, extra};
      return sum[4] ? 4'hF : sum[3:0];
   endfunction

endpackage

// File: rtl/vx_ahb_wait_gen.sv
// Wait-state counter for vx_ahb_sub_mem; with VX_AHB_SUB_RAND_WAIT_EN defined an LFSR
// adds 0..3 extra wait states per transfer.
module vx_ahb_wait_gen
   import vx_ahb_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       capture,
   input  logic       in_wait,
   output logic [3:0] load_val,
   output logic       wait_done
);

   localparam logic [3:0] WAIT_BASE = 4'(WAIT_CYCLES);

   logic [3:0] cnt;

`ifdef VX_AHB_SUB_RAND_WAIT_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16/14/13/11, stepped once per accepted address phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         lfsr <= 16'hACE1;
      else if (capture)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign load_val = sat_wait(WAIT_BASE, lfsr[1:0]);
`else
   assign load_val = WAIT_BASE;
`endif

   // A zero load bypasses the WAIT state, so the counter never wraps below zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= 4'd0;
      else if (capture)
         cnt <= load_val;
      else if (in_wait && cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   assign wait_done = (cnt == 4'd1);

endmodule

// File: rtl/vx_ahb_sub_mem.sv
// AHB-Lite subordinate word memory with programmable wait states and ERROR responses.
// Optional macro VX_AHB_SUB_RAND_WAIT_EN enables LFSR wait-state jitter in vx_ahb_wait_gen.
module vx_ahb_sub_mem
   import vx_ahb_pkg::*;
#(
   parameter int                        AHB_ADDR_WIDTH = 32,
   parameter int                        AHB_DATA_WIDTH = 32,
   parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                        DEPTH_WORDS    = 4096,
   parameter int                        WAIT_CYCLES    = 1
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        HSEL,
   input  logic [AHB_ADDR_WIDTH-1:0]   HADDR,
   input  logic [1:0]                  HTRANS,
   input  logic                        HWRITE,
   input  logic [2:0]                  HSIZE,
   input  logic [AHB_DATA_WIDTH-1:0]   HWDATA,
   input  logic [AHB_DATA_WIDTH/8-1:0] HWSTRB,
   output logic                        HREADY,
   output logic [AHB_DATA_WIDTH-1:0]   HRDATA,
   output logic                        HRESP
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int NB    = AHB_DATA_WIDTH / 8;

   sub_state_t                state;
   sub_state_t                state_nx;
   logic                      hready_q;
   logic                      hresp_q;
   logic [IDX_W-1:0]          idx_q;
   logic                      wr_q;
   logic [AHB_DATA_WIDTH-1:0] hrdata_q;
   logic [AHB_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   htrans_t                   trans;
   logic                      capture;
   logic                      addr_err;
   logic                      in_wait;
   logic                      wait_done;
   logic [3:0]                load_val;
   logic                      rd_phase;
   logic                      wr_phase;
   logic [AHB_ADDR_WIDTH:0]   diff;
   logic                      unused_diff_lsb;

   assign trans   = htrans_t'(HTRANS);
   assign capture = HSEL && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ) && hready_q;

   // The extra top bit of diff is the borrow (address below base); any offset bit at or above
   // the array size means the address lies past the last word.
   assign diff     = {1'b0, HADDR} - {1'b0, BASE_ADDR};
   assign addr_err = diff[AHB_ADDR_WIDTH]
                   || (|diff[AHB_ADDR_WIDTH-1:IDX_W+2])
                   || (HADDR[1:0] != 2'b00)
                   || (HSIZE != HSIZE_WORD);
   assign unused_diff_lsb = ^diff[1:0];

   assign in_wait  = (state == ST_WAIT);
   assign rd_phase = (state == ST_DATA) && !wr_q;
   assign wr_phase = (state == ST_DATA) && wr_q;

   vx_ahb_wait_gen #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_gen (
      .clk       (clk),
      .reset     (reset),
      .capture   (capture),
      .in_wait   (in_wait),
      .load_val  (load_val),
      .wait_done (wait_done)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_WAIT: if (wait_done) state_nx = ST_DATA;
         ST_ERR1: state_nx = ST_ERR2;
         default: begin
            // IDLE, DATA and ERR2 all accept a new address phase in the same cycle.
            if (!capture)
               state_nx = ST_IDLE;
            else if (addr_err)
               state_nx = ST_ERR1;
            else if (load_val == 4'd0)
               state_nx = ST_DATA;
            else
               state_nx = ST_WAIT;
         end
      endcase
   end

   // Outputs are registered from the next state so HREADY/HRESP never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state    <= state_nx;
         hready_q <= !(state_nx == ST_WAIT || state_nx == ST_ERR1);
         hresp_q  <= (state_nx == ST_ERR1 || state_nx == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
         if (capture) begin
            idx_q <= diff[IDX_W+1:2];
            wr_q  <= HWRITE;
         end
         if (rd_phase)
            hrdata_q <= mem[idx_q];
      end
   end

   // Reset forces state to IDLE asynchronously, so an interrupted write never commits.
   always_ff @(posedge clk) begin
      if (wr_phase) begin
         for (int i = 0; i < NB; i++) begin
            if (HWSTRB[i])
               mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign HREADY = hready_q;
   assign HRESP  = hresp_q;
   assign HRDATA = rd_phase ? mem[idx_q] : hrdata_q;

endmodule

// File: tb/tb_vx_ahb_sub_mem.sv
// Scoreboard bench for vx_ahb_sub_mem: three instances (0, 1 and 3 wait states) share one bus,
// each selected in turn through its own HSEL.
module tb_vx_ahb_sub_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        hsel;
   int          sel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [3:0]  hwstrb;

   logic        hsel0, hsel1, hsel2;
   logic        hready0, hready1, hready2;
   logic        hresp0, hresp1, hresp2;
   logic [31:0] hrdata0, hrdata1, hrdata2;
   logic        cur_hready, cur_hresp;
   logic [31:0] cur_hrdata;

   assign hsel0 = hsel && (sel == 0);
   assign hsel1 = hsel && (sel == 1);
   assign hsel2 = hsel && (sel == 2);

   vx_ahb_sub_mem #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready0), .HRDATA(hrdata0), .HRESP(hresp0));
   vx_ahb_sub_mem #(.WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready1), .HRDATA(hrdata1), .HRESP(hresp1));
   vx_ahb_sub_mem #(.WAIT_CYCLES(3)) u_dut2 (
      .clk(clk), .reset(reset), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready2), .HRDATA(hrdata2), .HRESP(hresp2));

   always_comb begin
      cur_hready = hready2;
      cur_hresp  = hresp2;
      cur_hrdata = hrdata2;
      case (sel)
         0: begin cur_hready = hready0; cur_hresp = hresp0; cur_hrdata = hrdata0; end
         1: begin cur_hready = hready1; cur_hresp = hresp1; cur_hrdata = hrdata1; end
         default: ;
      endcase
   end

   function automatic int waits_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 1 : 3;
   endfunction

   typedef struct {
      logic        err;
      logic        rd;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [int];
   int          checks = 0;
   int          errors = 0;
   int          stalls = 0;
   int          wcnt   = 0;
   logic        mon_en = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, sel, act, exp, $time);
      end
   endfunction

   // Monitor: retires the oldest expected transfer when its data phase ends (HREADY=1).
   always @(negedge clk) begin
      if (mon_en) begin
         if (q.size() > 0) begin
            if (!cur_hready) begin
               wcnt++;
               chk("hresp_stall", {31'b0, cur_hresp}, {31'b0, q[0].err});
            end else begin
               chk("hresp_done", {31'b0, cur_hresp}, {31'b0, q[0].err});
               chk("wait_states", 32'(wcnt), q[0].err ? 32'd1 : 32'(waits_of(sel)));
               if (q[0].rd && q[0].chk && !q[0].err)
                  chk("hrdata", cur_hrdata, q[0].data);
               void'(q.pop_front());
               wcnt = 0;
            end
         end else begin
            chk("idle_hready", {31'b0, cur_hready}, 32'd1);
            chk("idle_hresp", {31'b0, cur_hresp}, 32'd0);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the address phase is accepted.
   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] d, input logic [3:0] s);
      exp_t        e;
      int          key;
      int          n;
      logic [31:0] nv;
      hsel   = 1'b1;
      haddr  = a;
      htrans = 2'b10;
      hwrite = w;
      hsize  = sz;
      n      = 0;
      @(negedge clk);
      while (!cur_hready) begin
         stalls++;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout dut=%0d addr=%h", sel, a);
            hsel = 1'b0; htrans = 2'b00;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = d;
      hwstrb = s;
      e.err  = (a >= 32'h4000) || (a[1:0] != 2'b00) || (sz != 3'b010);
      e.rd   = !w;
      e.chk  = 1'b0;
      e.data = 32'h0;
      key    = sel * 65536 + int'(a >> 2);
      if (!e.err) begin
         if (w) begin
            nv = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int i = 0; i < 4; i++)
               if (s[i]) nv[8*i +: 8] = d[8*i +: 8];
            mdl[key] = nv;
         end else if (mdl.exists(key)) begin
            e.chk  = 1'b1;
            e.data = mdl[key];
         end
      end
      q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout dut=%0d pending=%0d", sel, q.size());
         q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      hsel   = 1'b0;
      sel    = 0;
      haddr  = 32'h0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'b010;
      hwdata = 32'h0;
      hwstrb = 4'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_hready0", {31'b0, hready0}, 32'd1);
      chk("rst_hready1", {31'b0, hready1}, 32'd1);
      chk("rst_hready2", {31'b0, hready2}, 32'd1);
      chk("rst_hresp0", {31'b0, hresp0}, 32'd0);
      chk("rst_hresp1", {31'b0, hresp1}, 32'd0);
      chk("rst_hresp2", {31'b0, hresp2}, 32'd0);
      chk("rst_hrdata0", hrdata0, 32'h0);
      chk("rst_hrdata1", hrdata1, 32'h0);
      chk("rst_hrdata2", hrdata2, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_hready0", {31'b0, hready0}, 32'd1);
      chk("post_rst_hready1", {31'b0, hready1}, 32'd1);
      chk("post_rst_hready2", {31'b0, hready2}, 32'd1);
      mon_en = 1'b1;

      // One wait state: single write/read, partial strobes, error responses.
      sel = 1;
      issue(32'h40, 1'b1, 3'b010, 32'hDEADBEEF, 4'hF);
      drain();
      issue(32'h40, 1'b0, 3'b010, 32'h0, 4'h0);
      issue(32'h80, 1'b1, 3'b010, 32'hFFFFFFFF, 4'hF);
      issue(32'h80, 1'b1, 3'b010, 32'h11223344, 4'b0101);
      issue(32'h80, 1'b0, 3'b010, 32'h0, 4'h0);
      drain();
      issue(32'h4000, 1'b0, 3'b010, 32'h0, 4'h0);
      issue(32'h40, 1'b0, 3'b010, 32'h0, 4'h0);
      issue(32'h44, 1'b0, 3'b000, 32'h0, 4'h0);
      issue(32'h42, 1'b0, 3'b010, 32'h0, 4'h0);
      issue(32'h40, 1'b0, 3'b010, 32'h0, 4'h0);
      drain();

      // Zero wait states: adapter-style 16-beat passes must never stall.
      sel    = 0;
      stalls = 0;
      for (int i = 0; i < 16; i++)
         issue(32'h1000 + 32'(4 * i), 1'b1, 3'b010, 32'hA5000000 ^ 32'(i * 32'h01010101), 4'hF);
      for (int i = 0; i < 16; i++)
         issue(32'h1000 + 32'(4 * i), 1'b0, 3'b010, 32'h0, 4'h0);
      issue(32'h103C, 1'b1, 3'b010, 32'h5EED1234, 4'hF);
      issue(32'h103C, 1'b0, 3'b010, 32'h0, 4'h0);
      drain();
      chk("burst_stalls", 32'(stalls), 32'd0);

      // Randomized traffic on every instance.
      for (int k = 0; k < 3; k++) begin
         sel = k;
         for (int n = 0; n < 80; n++) begin
            int          r;
            int          word;
            int          key;
            logic [3:0]  s;
            logic [31:0] a;
            r    = int'($urandom_range(0, 99));
            word = 32'h300 + int'($urandom_range(0, 63));
            a    = 32'(word * 4);
            key  = k * 65536 + word;
            if (r < 55) begin
               s = mdl.exists(key) ? 4'($urandom_range(1, 15)) : 4'hF;
               issue(a, 1'b1, 3'b010, $urandom, s);
            end else if (r < 88) begin
               issue(a, 1'b0, 3'b010, 32'h0, 4'h0);
            end else if (r < 93) begin
               issue(32'h4000 + 32'(4 * $urandom_range(0, 1000)), r[0], 3'b010, $urandom, 4'hF);
            end else if (r < 97) begin
               issue(a + 32'($urandom_range(1, 3)), r[0], 3'b010, $urandom, 4'hF);
            end else begin
               issue(a, r[0], 3'($urandom_range(0, 1)), $urandom, 4'hF);
            end
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
         drain();
      end

      // Reset during the second wait cycle of a 3-wait write drops the write.
      sel = 2;
      issue(32'h200, 1'b1, 3'b010, 32'h12345678, 4'hF);
      drain();
      mon_en = 1'b0;
      hsel   = 1'b1;
      haddr  = 32'h200;
      htrans = 2'b10;
      hwrite = 1'b1;
      hsize  = 3'b010;
      @(posedge clk);
      #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = 32'hCAFEF00D;
      hwstrb = 4'hF;
      @(posedge clk);
      #1;
      chk("abort_in_wait", {31'b0, cur_hready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("async_rst_hready", {31'b0, cur_hready}, 32'd1);
      chk("async_rst_hresp", {31'b0, cur_hresp}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      wcnt   = 0;
      mon_en = 1'b1;
      issue(32'h200, 1'b0, 3'b010, 32'h0, 4'h0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
